// File: rtl/regfile_mips.sv
// MIPS 32x32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero; $gp and $sp take parameterised reset values.
module regfile_mips #(
  parameter logic [31:0] SP_INIT = 32'h7fffeffc,
  parameter logic [31:0] GP_INIT = 32'h10008000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        reg_write,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned GP_IDX   = 28;
  localparam int unsigned SP_IDX   = 29;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset wins over a same-cycle write; writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i == GP_IDX)      regs[ADDR_W'(i)] <= GP_INIT;
        else if (i == SP_IDX) regs[ADDR_W'(i)] <= SP_INIT;
        else                  regs[ADDR_W'(i)] <= '0;
      end
    end else if (reg_write && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  // Reads come only from stored state, so there is no path from write_data.
  assign read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];

endmodule

// File: tb/tb_regfile_mips.sv
// Self-checking bench for regfile_mips: array reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_regfile_mips;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  bit model_valid = 1'b0;

  regfile_mips #(.SP_INIT(32'h7fffeffc), .GP_INIT(32'h10008000)) dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: an array updated by the architectural rules.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[28] = 32'h10008000;
      model[29] = 32'h7fffeffc;
      model_valid = 1'b1;
    end else if (reg_write === 1'b1 && write_reg != 5'd0) begin
      model[write_reg] = write_data;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_port1", read_data1, model[read_reg1]);
      check("model_port2", read_data2, model[read_reg2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    write_reg  = idx;
    write_data = data;
    reg_write  = 1'b1;
    step();
    reg_write  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    reset = 1'b0; reg_write = 1'b0;
    read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;

    // One-cycle reset pulse, then sweep port 1 over every index.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      #1;
      if (i == 28)      exp = 32'h10008000;
      else if (i == 29) exp = 32'h7fffeffc;
      else              exp = 32'h0;
      check($sformatf("reset_val_r%0d", i), read_data1, exp);
    end

    // Write then read back on both ports.
    wr(5'd8, 32'hdeadbeef);
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    check("wr8_port1", read_data1, 32'hdeadbeef);
    check("wr8_port2", read_data2, 32'hdeadbeef);

    // Register 0 ignores writes.
    wr(5'd0, 32'hffffffff);
    read_reg1 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("r0_zero", read_data1, 32'h0);
      step();
    end

    // No write-to-read bypass.
    wr(5'd9, 32'd5);
    read_reg2 = 5'd9;
    write_reg = 5'd9; write_data = 32'd7; reg_write = 1'b1;
    #1;
    check("nobypass_before", read_data2, 32'd5);
    step();
    reg_write = 1'b0;
    check("nobypass_after", read_data2, 32'd7);

    // Disabled write leaves register 10 unchanged.
    write_reg = 5'd10; write_data = 32'd3; reg_write = 1'b0;
    step();
    read_reg1 = 5'd10;
    #1;
    check("wen_off_r10", read_data1, 32'h0);

    // Reset beats a simultaneous write and clears earlier writes.
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd10; write_data = 32'd3;
    step();
    reset = 1'b0; reg_write = 1'b0;
    read_reg1 = 5'd10; read_reg2 = 5'd8;
    #1;
    check("rst_prio_r10", read_data1, 32'h0);
    check("rst_clear_r8", read_data2, 32'h0);
    read_reg1 = 5'd29; read_reg2 = 5'd9;
    #1;
    check("rst_sp", read_data1, 32'h7fffeffc);
    check("rst_clear_r9", read_data2, 32'h0);

    // Random traffic checked by the model on every cycle.
    for (int n = 0; n < 1000; n++) begin
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      reg_write  = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; reg_write = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
